timer_multi: RTL and testbench

- Parametrised multi-channel successor to the single-counter memory-mapped timer.
- N_CH independent channels. Each has:
  - a prescaler;
  - a CNT_W-bit up-counter;
  - a compare register with optional auto-reload;
  - a match status bit.
- Shared W1C status register and one level interrupt output for the core's interrupt logic.
- Channel 0 at offsets 0x0/0x4 is register-compatible with the legacy timer (COUNT, enable bit 0, enabled after reset).

---
 rtl/timer_pkg.sv | 56 +++++
 rtl/timer_channel.sv | 109 ++++++++++
 rtl/timer_multi.sv | 131 +++++++++++++
 tb/tb_timer_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and decode helpers for the multi-channel timer.
package timer_pkg;

    localparam logic [4:0]  OFF_COUNT   = 5'h00;
    localparam logic [4:0]  OFF_CTRL    = 5'h04;
    localparam logic [4:0]  OFF_COMPARE = 5'h08;
    localparam logic [4:0]  OFF_PRESC   = 5'h0C;
    localparam logic [4:0]  OFF_CAPTURE = 5'h10;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0100;

    localparam logic [31:0] CH_STRIDE = 32'h0000_0020;
    localparam int          CH_SHIFT  = $clog2(CH_STRIDE);

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;
    localparam int CTRL_W  = 3;

    typedef struct packed {
        logic count;
        logic ctrl;
        logic compare;
        logic presc;
    } ch_wr_t;

    typedef enum logic [2:0] {
        REG_COUNT,
        REG_CTRL,
        REG_COMPARE,
        REG_PRESC,
        REG_CAPTURE,
        REG_NONE
    } reg_sel_e;

    // Channel registers live in 0x000-0x0FF; anything above is global or unmapped.
    function automatic reg_sel_e decode_reg(input logic [31:0] addr);
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr[31:8] == 24'h0) begin
            case (addr[4:0])
                OFF_COUNT:   sel = REG_COUNT;
                OFF_CTRL:    sel = REG_CTRL;
                OFF_COMPARE: sel = REG_COMPARE;
                OFF_PRESC:   sel = REG_PRESC;
                OFF_CAPTURE: sel = REG_CAPTURE;
                default:     sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [2:0] decode_ch(input logic [31:0] addr);
        return addr[CH_SHIFT +: 3];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, counter, compare/auto-reload and optional input capture.
// Capture logic is present only when TIMER_CAPTURE_EN is defined.
module timer_channel
    import timer_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter int               PRESC_W  = 16,
    parameter logic [CTRL_W-1:0] RST_CTRL = '0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clk_enable_i,
    input  ch_wr_t             wr_i,
    input  logic [31:0]        wdata_i,
`ifdef TIMER_CAPTURE_EN
    input  logic               capture_i,
`endif
    output logic [CNT_W-1:0]   count_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [CNT_W-1:0]   compare_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic [CNT_W-1:0]   capture_o,
    output logic               match_o,
    output logic               capture_evt_o
);

    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   compare_q, compare_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               tick;
    logic               hit;

    always_comb begin
        tick = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
        hit  = tick && !wr_i.count && (count_q == compare_q);

        pcnt_d = pcnt_q;
        if (ctrl_q[CTRL_EN]) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
        if (wr_i.presc) begin
            pcnt_d = '0;
        end

        // A bus write to COUNT overrides whatever the tick would have done.
        count_d = count_q;
        if (wr_i.count) begin
            count_d = wdata_i[CNT_W-1:0];
        end else if (tick) begin
            count_d = (hit && ctrl_q[CTRL_AR]) ? '0 : count_q + 1'b1;
        end

        ctrl_d    = wr_i.ctrl    ? wdata_i[CTRL_W-1:0]  : ctrl_q;
        compare_d = wr_i.compare ? wdata_i[CNT_W-1:0]   : compare_q;
        presc_d   = wr_i.presc   ? wdata_i[PRESC_W-1:0] : presc_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pcnt_q    <= '0;
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '1;
            ctrl_q    <= RST_CTRL;
        end else if (clk_enable_i) begin
            pcnt_q    <= pcnt_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign count_o   = count_q;
    assign ctrl_o    = ctrl_q;
    assign compare_o = compare_q;
    assign presc_o   = presc_q;
    assign match_o   = hit;

`ifdef TIMER_CAPTURE_EN
    // sync_q[0..1] form the two-flop synchroniser, sync_q[2] holds the previous sample.
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] capture_q;
    logic             cap_edge;

    assign cap_edge = sync_q[1] && !sync_q[2];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q    <= '0;
            capture_q <= '0;
        end else if (clk_enable_i) begin
            sync_q <= {sync_q[1:0], capture_i};
            if (cap_edge) begin
                capture_q <= count_q;
            end
        end
    end

    assign capture_o     = capture_q;
    assign capture_evt_o = cap_edge;
`else
    assign capture_o     = '0;
    assign capture_evt_o = 1'b0;
`endif

endmodule

// File: rtl/timer_multi.sv
// Multi-channel memory-mapped timer: address decode, read mux, W1C STATUS and registered irq.
// Optional input capture is enabled by defining TIMER_CAPTURE_EN.
module timer_multi
    import timer_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clk_enable,
    input  logic              bus_r_en,
    input  logic [31:0]       bus_r_addr,
    output logic [31:0]       bus_r_data,
    input  logic              bus_w_en,
    input  logic [31:0]       bus_w_addr,
    input  logic [31:0]       bus_w_data,
    output logic              irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic [N_CH-1:0]   capture_in
`endif
);

    logic [CNT_W-1:0]   ch_count   [N_CH];
    logic [CTRL_W-1:0]  ch_ctrl    [N_CH];
    logic [CNT_W-1:0]   ch_compare [N_CH];
    logic [PRESC_W-1:0] ch_presc   [N_CH];
    logic [CNT_W-1:0]   ch_capture [N_CH];
    ch_wr_t             ch_wr      [N_CH];
    logic [N_CH-1:0]    match_pulse;
    logic [N_CH-1:0]    cap_pulse;
    logic [N_CH-1:0]    ie_vec;

    logic [2*N_CH-1:0]  status_q, status_d;
    logic               irq_q, irq_d;

    logic               wr_go;
    logic [2:0]         w_idx, r_idx;
    reg_sel_e           w_sel, r_sel;

    assign wr_go = clk_enable && bus_w_en;
    assign w_idx = decode_ch(bus_w_addr);
    assign w_sel = decode_reg(bus_w_addr);
    assign r_idx = decode_ch(bus_r_addr);
    assign r_sel = decode_reg(bus_r_addr);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic sel_ch;
            assign sel_ch = wr_go && (w_idx == 3'(gi));
            assign ch_wr[gi] = '{
                count:   sel_ch && (w_sel == REG_COUNT),
                ctrl:    sel_ch && (w_sel == REG_CTRL),
                compare: sel_ch && (w_sel == REG_COMPARE),
                presc:   sel_ch && (w_sel == REG_PRESC)
            };
            assign ie_vec[gi] = ch_ctrl[gi][CTRL_IE];

            // Channel 0 powers up enabled so it behaves like the legacy single timer.
            timer_channel #(
                .CNT_W    (CNT_W),
                .PRESC_W  (PRESC_W),
                .RST_CTRL ((gi == 0) ? 3'b001 : 3'b000)
            ) u_ch (
                .clk           (clk),
                .n_rst         (n_rst),
                .clk_enable_i  (clk_enable),
                .wr_i          (ch_wr[gi]),
                .wdata_i       (bus_w_data),
`ifdef TIMER_CAPTURE_EN
                .capture_i     (capture_in[gi]),
`endif
                .count_o       (ch_count[gi]),
                .ctrl_o        (ch_ctrl[gi]),
                .compare_o     (ch_compare[gi]),
                .presc_o       (ch_presc[gi]),
                .capture_o     (ch_capture[gi]),
                .match_o       (match_pulse[gi]),
                .capture_evt_o (cap_pulse[gi])
            );
        end
    endgenerate

    always_comb begin
        logic [2*N_CH-1:0] w1c;
        w1c = '0;
        if (wr_go && (bus_w_addr == OFF_STATUS)) begin
            w1c = bus_w_data[2*N_CH-1:0];
        end
        // New events override a simultaneous clear so no event is lost.
        status_d = (status_q & ~w1c) | {cap_pulse, match_pulse};
        irq_d    = |(status_q[N_CH-1:0] & ie_vec) | |(status_q[2*N_CH-1:N_CH] & ie_vec);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else if (clk_enable) begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        bus_r_data = '0;
        if (bus_r_en) begin
            if (bus_r_addr == OFF_STATUS) begin
                bus_r_data = 32'(status_q);
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (r_idx == 3'(c)) begin
                        case (r_sel)
                            REG_COUNT:   bus_r_data = 32'(ch_count[c]);
                            REG_CTRL:    bus_r_data = 32'(ch_ctrl[c]);
                            REG_COMPARE: bus_r_data = 32'(ch_compare[c]);
                            REG_PRESC:   bus_r_data = 32'(ch_presc[c]);
                            REG_CAPTURE: bus_r_data = 32'(ch_capture[c]);
                            default:     bus_r_data = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi (N_CH=2, CNT_W=32, PRESC_W=16).
module tb_timer_multi;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        clk_enable = 1'b1;
    logic        bus_r_en = 1'b0;
    logic [31:0] bus_r_addr = '0;
    logic [31:0] bus_r_data;
    logic        bus_w_en = 1'b0;
    logic [31:0] bus_w_addr = '0;
    logic [31:0] bus_w_data = '0;
    logic        irq;
`ifdef TIMER_CAPTURE_EN
    logic [1:0]  capture_in = '0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_multi #(.N_CH(2), .CNT_W(32), .PRESC_W(16)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clk_enable (clk_enable),
        .bus_r_en   (bus_r_en),
        .bus_r_addr (bus_r_addr),
        .bus_r_data (bus_r_data),
        .bus_w_en   (bus_w_en),
        .bus_w_addr (bus_w_addr),
        .bus_w_data (bus_w_data),
        .irq        (irq)
`ifdef TIMER_CAPTURE_EN
        ,
        .capture_in (capture_in)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_w_en   = 1'b1;
        bus_w_addr = addr;
        bus_w_data = data;
        @(posedge clk);
        #1;
        bus_w_en   = 1'b0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_r_en   = 1'b1;
        bus_r_addr = addr;
        #1;
        d = bus_r_data;
        bus_r_en = 1'b0;
        $display("read  %s addr=%h data=%h", tag, addr, d);
        chk(tag, d, exp);
    endtask

    initial begin
        // Reset and legacy-compatible defaults
        tick(2);
        n_rst = 1'b1;
        rd_chk("rst_count0", 32'h00, 32'h0);
        rd_chk("rst_ctrl0", 32'h04, 32'h1);
        rd_chk("rst_cmp0", 32'h08, 32'hFFFF_FFFF);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rd_chk("rst_status", 32'h100, 32'h0);
        tick(10);
        rd_chk("free_count0", 32'h00, 32'd10);
        rd_chk("free_count1", 32'h20, 32'd0);
        rd_chk("free_ctrl0", 32'h04, 32'h1);
        chk("free_irq", {31'b0, irq}, 32'h0);
        bus_r_addr = 32'h00;
        #1;
        chk("r_en_low", bus_r_data, 32'h0);

        // ch1 prescaled auto-reload with irq
        wr(32'h2C, 32'd3);
        wr(32'h28, 32'd4);
        wr(32'h24, 32'h7);
        rd_chk("ch1_c0", 32'h20, 32'd0);
        tick(3);
        rd_chk("ch1_hold", 32'h20, 32'd0);
        tick(1);
        rd_chk("ch1_c1", 32'h20, 32'd1);
        tick(12);
        rd_chk("ch1_c4", 32'h20, 32'd4);
        rd_chk("ch1_st0", 32'h100, 32'h0);
        tick(3);
        chk("ch1_irq_pre", {31'b0, irq}, 32'h0);
        tick(1);
        rd_chk("ch1_reload", 32'h20, 32'd0);
        rd_chk("ch1_st_set", 32'h100, 32'h2);
        chk("ch1_irq_lat", {31'b0, irq}, 32'h0);
        tick(1);
        chk("ch1_irq_hi", {31'b0, irq}, 32'h1);
        wr(32'h100, 32'h2);
        rd_chk("ch1_st_clr", 32'h100, 32'h0);
        chk("ch1_irq_still", {31'b0, irq}, 32'h1);
        tick(1);
        chk("ch1_irq_lo", {31'b0, irq}, 32'h0);
        wr(32'h24, 32'h0);

        // ch0 wrap without flag, then match at 5
        wr(32'h08, 32'd5);
        wr(32'h00, 32'hFFFF_FFFE);
        rd_chk("wrap_fe", 32'h00, 32'hFFFF_FFFE);
        tick(1);
        rd_chk("wrap_ff", 32'h00, 32'hFFFF_FFFF);
        tick(1);
        rd_chk("wrap_0", 32'h00, 32'h0);
        rd_chk("wrap_noflag", 32'h100, 32'h0);
        tick(1);
        rd_chk("wrap_1", 32'h00, 32'h1);
        tick(4);
        rd_chk("m5_cnt", 32'h00, 32'd5);
        rd_chk("m5_st0", 32'h100, 32'h0);
        tick(1);
        rd_chk("m5_cnt6", 32'h00, 32'd6);
        rd_chk("m5_flag", 32'h100, 32'h1);
        tick(1);
        chk("m5_irq_masked", {31'b0, irq}, 32'h0);
        wr(32'h100, 32'h1);
        rd_chk("m5_clr", 32'h100, 32'h0);

        // Match and W1C of the same bit together: set wins
        wr(32'h00, 32'd3);
        tick(2);
        wr(32'h100, 32'h1);
        rd_chk("setwin_cnt", 32'h00, 32'd6);
        rd_chk("setwin_flag", 32'h100, 32'h1);
        wr(32'h100, 32'h1);
        rd_chk("setwin_clr", 32'h100, 32'h0);

        // COUNT write on a matching tick: write wins, no flag
        wr(32'h00, 32'd4);
        tick(1);
        wr(32'h00, 32'd50);
        rd_chk("cw_val", 32'h00, 32'd50);
        rd_chk("cw_noflag", 32'h100, 32'h0);

        // clk_enable low freezes state and blocks writes
        clk_enable = 1'b0;
        wr(32'h00, 32'h1234);
        wr(32'h24, 32'h7);
        tick(3);
        rd_chk("frz_cnt", 32'h00, 32'd50);
        rd_chk("frz_ctrl1", 32'h24, 32'h0);
        clk_enable = 1'b1;
        tick(1);
        rd_chk("frz_resume", 32'h00, 32'd51);

        // Unmapped and out-of-range channel reads
        rd_chk("unm_0fc", 32'h0FC, 32'h0);
        rd_chk("unm_200", 32'h200, 32'h0);
        rd_chk("unm_ch2", 32'h040, 32'h0);
        tick(1);
        rd_chk("unm_ch3c", 32'h064, 32'h0);
        rd_chk("unm_0x14", 32'h014, 32'h0);
`ifndef TIMER_CAPTURE_EN
        rd_chk("cap_absent", 32'h010, 32'h0);
`endif

        // Asynchronous reset mid-count
        #2;
        n_rst = 1'b0;
        #1;
        rd_chk("arst_cnt", 32'h00, 32'h0);
        rd_chk("arst_cmp", 32'h08, 32'hFFFF_FFFF);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

`ifdef TIMER_CAPTURE_EN
        // Capture: pulse at COUNT=20 latches 22 after the synchroniser
        wr(32'h04, 32'h5);
        tick(19);
        rd_chk("cap_at20", 32'h00, 32'd20);
        capture_in[0] = 1'b1;
        tick(3);
        rd_chk("cap_val", 32'h10, 32'd22);
        rd_chk("cap_flag", 32'h100, 32'h4);
        tick(1);
        chk("cap_irq", {31'b0, irq}, 32'h1);
        capture_in[0] = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
